// File: rtl/board_ctl_if.sv
// Request/result/memory bundle between the game logic, the board memory and board_ctl.
// The slave modport is the board_ctl view; the master modport is the game logic and memory side.
interface board_ctl_if #(
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH   = 2
);
    logic                                 clear_req;
    logic                                 busy;
    logic                                 place_valid;
    logic                                 place_ready;
    logic [X_ADDR_WIDTH-1:0]              place_x;
    logic [Y_ADDR_WIDTH-1:0]              place_y;
    logic                                 shot_valid;
    logic                                 shot_ready;
    logic [X_ADDR_WIDTH-1:0]              shot_x;
    logic [Y_ADDR_WIDTH-1:0]              shot_y;
    logic                                 result_valid;
    logic                                 result_src;
    logic [DATA_WIDTH-1:0]                result_code;
    logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_read_addr;
    logic [DATA_WIDTH-1:0]                mem_read_data;
    logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_write_addr;
    logic [DATA_WIDTH-1:0]                mem_write_data;
    logic                                 mem_write_enable;

    modport slave (
        input  clear_req, place_valid, place_x, place_y, shot_valid, shot_x, shot_y, mem_read_data,
        output busy, place_ready, shot_ready, result_valid, result_src, result_code,
        output mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
    );

    modport master (
        output clear_req, place_valid, place_x, place_y, shot_valid, shot_x, shot_y, mem_read_data,
        input  busy, place_ready, shot_ready, result_valid, result_src, result_code,
        input  mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/board_ctl.sv
// Game board sequencer: clears the board memory, then serves place/shot requests
// round-robin as single-cell read-modify-write operations and reports the old cell value.
module board_ctl #(
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4,
    parameter int X_SIZE       = 16,
    parameter int Y_SIZE       = 16,
    parameter int DATA_WIDTH   = 2,
    parameter int RD_LATENCY   = 1
) (
    input  logic clk,
    input  logic rst_n,
    board_ctl_if.slave bus
);
    localparam int ADDR_W = X_ADDR_WIDTH + Y_ADDR_WIDTH;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int CELLS  = X_SIZE * Y_SIZE;

    localparam logic [CNT_W-1:0] CLEAR_END = CELLS[CNT_W-1:0];
    localparam logic [1:0]       WAIT_LAST = 2'(RD_LATENCY - 1);

    localparam logic [DATA_WIDTH-1:0] CELL_EMPTY = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] CELL_SHIP  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] CELL_HIT   = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] CELL_MISS  = DATA_WIDTH'(3);

    localparam logic [2:0] S_CLEAR  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] clear_cnt;
    logic [1:0]       wait_cnt;
    logic             rr_shot;     // 1: shot wins the next tie, 0: place wins
    logic             clear_pend;
    logic             op_src;
    logic             idle_open;
    logic             grant_place;
    logic             grant_shot;
    logic [DATA_WIDTH:0] upd;      // {write, new cell value} for the cell being updated

    // Returns {write_needed, new_value} for a request of the given source on a cell holding old_val.
    function automatic logic [DATA_WIDTH:0] cell_update(input logic src,
                                                        input logic [DATA_WIDTH-1:0] old_val);
        logic [DATA_WIDTH:0] r;
        r = {1'b0, old_val};
        if (!src) begin
            if (old_val == CELL_EMPTY) r = {1'b1, CELL_SHIP};
        end else begin
            if (old_val == CELL_EMPTY)     r = {1'b1, CELL_MISS};
            else if (old_val == CELL_SHIP) r = {1'b1, CELL_HIT};
        end
        return r;
    endfunction

    // Round-robin grant, only in IDLE and never while a clear is waiting to run.
    always_comb begin
        idle_open   = (state == S_IDLE) && !clear_pend && !bus.clear_req;
        grant_place = idle_open && bus.place_valid && (!bus.shot_valid || !rr_shot);
        grant_shot  = idle_open && bus.shot_valid && (!bus.place_valid || rr_shot);
        upd         = cell_update(op_src, bus.mem_read_data);
    end

    assign bus.place_ready = grant_place;
    assign bus.shot_ready  = grant_shot;

    // Sequencer state, clear counter, arbitration pointer and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= S_CLEAR;
            clear_cnt            <= '0;
            wait_cnt             <= '0;
            rr_shot              <= 1'b0;
            clear_pend           <= 1'b0;
            op_src               <= 1'b0;
            bus.busy             <= 1'b0;
            bus.result_valid     <= 1'b0;
            bus.result_src       <= 1'b0;
            bus.result_code      <= '0;
            bus.mem_read_addr    <= '0;
            bus.mem_write_addr   <= '0;
            bus.mem_write_data   <= '0;
            bus.mem_write_enable <= 1'b0;
        end else begin
            bus.result_valid     <= 1'b0;
            bus.mem_write_enable <= 1'b0;
            if (bus.clear_req && state != S_CLEAR) clear_pend <= 1'b1;

            case (state)
                S_CLEAR: begin
                    if (bus.clear_req) begin
                        // Restart: write cell 0 now, continue from cell 1.
                        bus.mem_write_enable <= 1'b1;
                        bus.mem_write_data   <= CELL_EMPTY;
                        bus.mem_write_addr   <= '0;
                        bus.mem_read_addr    <= '0;
                        clear_cnt            <= CNT_W'(1);
                        bus.busy             <= 1'b1;
                    end else if (clear_cnt == CLEAR_END) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        // Read address follows the write so both ports target the same cell.
                        bus.mem_write_enable <= 1'b1;
                        bus.mem_write_data   <= CELL_EMPTY;
                        bus.mem_write_addr   <= clear_cnt[ADDR_W-1:0];
                        bus.mem_read_addr    <= clear_cnt[ADDR_W-1:0];
                        clear_cnt            <= clear_cnt + 1'b1;
                        bus.busy             <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (clear_pend || bus.clear_req) begin
                        state                <= S_CLEAR;
                        clear_pend           <= 1'b0;
                        bus.mem_write_enable <= 1'b1;
                        bus.mem_write_data   <= CELL_EMPTY;
                        bus.mem_write_addr   <= '0;
                        bus.mem_read_addr    <= '0;
                        clear_cnt            <= CNT_W'(1);
                        bus.busy             <= 1'b1;
                    end else if (grant_place || grant_shot) begin
                        state             <= S_READ;
                        op_src            <= grant_shot;
                        rr_shot           <= grant_place;
                        bus.mem_read_addr <= grant_shot ? {bus.shot_y, bus.shot_x}
                                                        : {bus.place_y, bus.place_x};
                        bus.busy          <= 1'b1;
                    end
                end
                S_READ: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        // Old value is captured here so the write and result are visible in UPDATE.
                        state                <= S_UPDATE;
                        bus.result_valid     <= 1'b1;
                        bus.result_src       <= op_src;
                        bus.result_code      <= bus.mem_read_data;
                        bus.mem_write_enable <= upd[DATA_WIDTH];
                        bus.mem_write_data   <= upd[DATA_WIDTH-1:0];
                        bus.mem_write_addr   <= bus.mem_read_addr;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state     <= S_CLEAR;
                    clear_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_ctl.sv
// Bench for board_ctl: memory model, board reference model, vector table, random ops and corner sequences.
module tb_board_ctl;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int DW = 2;
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] SHIP  = 2'b01;
    localparam logic [1:0] HIT   = 2'b10;
    localparam logic [1:0] MISS  = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    board_ctl_if #(.X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW), .DATA_WIDTH(DW)) bus ();

    board_ctl #(.X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW), .X_SIZE(16), .Y_SIZE(16),
                .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Board memory: synchronous write, one-cycle registered read.
    logic [1:0] mem [256];
    logic [1:0] rd_q;
    logic       scramble = 1'b1;
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 256; i++) mem[i] <= 2'($urandom);
        end else if (bus.mem_write_enable) begin
            mem[bus.mem_write_addr] <= bus.mem_write_data;
        end
        rd_q <= mem[bus.mem_read_addr];
    end
    assign bus.mem_read_data = rd_q;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: board contents and which requester wins the next tie (0 place, 1 shot).
    logic [1:0] board [256];
    bit pref;

    typedef struct {
        logic       src;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] code;
        logic       wr;
        logic [1:0] wd;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) board[i] = EMPTY;
    endtask

    task automatic model_op(input bit src, input logic [7:0] a, output logic [1:0] old,
                            output bit wr, output logic [1:0] nv);
        old = board[a];
        wr  = 1'b0;
        nv  = old;
        if (!src) begin
            if (old == EMPTY) begin wr = 1'b1; nv = SHIP; end
        end else begin
            if (old == EMPTY)     begin wr = 1'b1; nv = MISS; end
            else if (old == SHIP) begin wr = 1'b1; nv = HIT;  end
        end
        board[a] = nv;
        pref = !src;
    endtask

    task automatic wait_result(output logic [1:0] code, output logic rsrc, output int nwr,
                               output logic [1:0] wdata, output logic [7:0] waddr, output int lat);
        code = 'x; rsrc = 'x; nwr = 0; wdata = 'x; waddr = 'x; lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_write_enable) begin
                nwr++;
                wdata = bus.mem_write_data;
                waddr = bus.mem_write_addr;
            end
            if (bus.result_valid) begin
                lat  = c;
                code = bus.result_code;
                rsrc = bus.result_src;
                break;
            end
        end
    endtask

    task automatic wait_ready(input bit src, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (src ? bus.shot_ready : bus.place_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string tag, input bit src, input logic [3:0] x, input logic [3:0] y,
                         output logic [1:0] code, output logic rsrc, output int nwr,
                         output logic [1:0] wdata, output logic [7:0] waddr, output int lat);
        bit ok;
        @(negedge clk);
        if (src) begin bus.shot_x = x;  bus.shot_y = y;  bus.shot_valid = 1'b1;  end
        else     begin bus.place_x = x; bus.place_y = y; bus.place_valid = 1'b1; end
        wait_ready(src, ok);
        check({tag, "_handshake"}, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.shot_valid  = 1'b0;
        bus.place_valid = 1'b0;
        wait_result(code, rsrc, nwr, wdata, waddr, lat);
    endtask

    task automatic check_res(input string tag, input logic [1:0] code, input logic rsrc, input int nwr,
                             input logic [1:0] wdata, input logic [7:0] waddr, input int lat,
                             input bit esrc, input logic [1:0] ecode, input bit ewr,
                             input logic [1:0] ewd, input logic [7:0] eaddr);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_src"}, 32'(rsrc), 32'(esrc));
        check({tag, "_code"}, 32'(code), 32'(ecode));
        check({tag, "_writes"}, 32'(nwr), ewr ? 32'd1 : 32'd0);
        if (ewr) begin
            check({tag, "_wdata"}, 32'(wdata), 32'(ewd));
            check({tag, "_waddr"}, 32'(waddr), 32'(eaddr));
        end
    endtask

    task automatic run_op(input string tag, input bit src, input logic [3:0] x, input logic [3:0] y);
        logic [1:0] code, wdata, old, nv;
        logic [7:0] waddr;
        logic rsrc;
        int nwr, lat;
        bit wr;
        do_op(tag, src, x, y, code, rsrc, nwr, wdata, waddr, lat);
        model_op(src, {y, x}, old, wr, nv);
        check_res(tag, code, rsrc, nwr, wdata, waddr, lat, src, old, wr, nv, {y, x});
    endtask

    task automatic watch_clear(input string tag);
        int nwr, nbusy, bad;
        bit started, done;
        nwr = 0; nbusy = 0; bad = 0; started = 1'b0; done = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (bus.mem_write_enable) begin
                started = 1'b1;
                if (bus.mem_write_addr != nwr[7:0] || bus.mem_write_data != EMPTY) bad++;
                nwr++;
            end
            if (started) begin
                if (bus.busy) nbusy++;
                else begin done = 1'b1; break; end
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_writes"}, 32'(nwr), 32'd256);
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'd256);
        check({tag, "_order_errors"}, 32'(bad), 32'd0);
        check({tag, "_we_after"}, 32'(bus.mem_write_enable), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] code, wdata, old, nv;
        logic [7:0] waddr;
        logic rsrc;
        int nwr, lat;
        bit wr, ok, got;

        bus.clear_req = 1'b0;
        bus.place_valid = 1'b0; bus.place_x = '0; bus.place_y = '0;
        bus.shot_valid  = 1'b0; bus.shot_x  = '0; bus.shot_y  = '0;

        vecs[0] = '{1'b0, 4'd3, 4'd5, EMPTY, 1'b1, SHIP};
        vecs[1] = '{1'b0, 4'd3, 4'd5, SHIP,  1'b0, EMPTY};
        vecs[2] = '{1'b1, 4'd3, 4'd5, SHIP,  1'b1, HIT};
        vecs[3] = '{1'b1, 4'd3, 4'd5, HIT,   1'b0, EMPTY};
        vecs[4] = '{1'b1, 4'd0, 4'd0, EMPTY, 1'b1, MISS};

        // Reset state, with garbage in memory so the clear is visible.
        repeat (3) @(negedge clk);
        scramble = 1'b0;
        bus.place_valid = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_we", 32'(bus.mem_write_enable), 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_place_ready", 32'(bus.place_ready), 32'd0);
        bus.place_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        watch_clear("boot_clear");
        model_clear();
        pref = 1'b0;

        // Single requester gets ready in IDLE.
        bus.place_valid = 1'b1;
        #1;
        check("idle_place_ready", 32'(bus.place_ready), 32'd1);
        check("idle_shot_ready_off", 32'(bus.shot_ready), 32'd0);
        bus.place_valid = 1'b0;
        bus.shot_valid = 1'b1;
        #1;
        check("idle_shot_ready", 32'(bus.shot_ready), 32'd1);
        bus.shot_valid = 1'b0;

        // Vector table.
        for (int v = 0; v < 5; v++) begin
            do_op($sformatf("vec%0d", v), vecs[v].src, vecs[v].x, vecs[v].y,
                  code, rsrc, nwr, wdata, waddr, lat);
            check_res($sformatf("vec%0d", v), code, rsrc, nwr, wdata, waddr, lat,
                      vecs[v].src, vecs[v].code, vecs[v].wr, vecs[v].wd, {vecs[v].y, vecs[v].x});
            model_op(vecs[v].src, {vecs[v].y, vecs[v].x}, old, wr, nv);
        end

        // Both requesters held valid for four operations.
        @(negedge clk);
        bus.place_x = 4'd1; bus.place_y = 4'd2; bus.place_valid = 1'b1;
        bus.shot_x  = 4'd7; bus.shot_y  = 4'd9; bus.shot_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (bus.place_ready || bus.shot_ready) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            check($sformatf("arb%0d_handshake", k), 32'(ok), 32'd1);
            check($sformatf("arb%0d_exclusive", k), 32'(bus.place_ready & bus.shot_ready), 32'd0);
            got = bus.shot_ready;
            check($sformatf("arb%0d_grant", k), 32'(got), 32'(pref));
            @(posedge clk);
            wait_result(code, rsrc, nwr, wdata, waddr, lat);
            if (k == 3) begin bus.place_valid = 1'b0; bus.shot_valid = 1'b0; end
            if (got) begin
                model_op(1'b1, {4'd9, 4'd7}, old, wr, nv);
                check_res($sformatf("arb%0d", k), code, rsrc, nwr, wdata, waddr, lat, 1'b1, old, wr, nv, 8'h97);
            end else begin
                model_op(1'b0, {4'd2, 4'd1}, old, wr, nv);
                check_res($sformatf("arb%0d", k), code, rsrc, nwr, wdata, waddr, lat, 1'b0, old, wr, nv, 8'h21);
            end
        end

        // Random operations on a small area so cells get revisited.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($sformatf("rnd%0d", n), bit'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end

        // clear_req during WAIT of a shot at a HIT cell: shot finishes, then clear runs.
        @(negedge clk);
        bus.shot_x = 4'd3; bus.shot_y = 4'd5; bus.shot_valid = 1'b1;
        wait_ready(1'b1, ok);
        check("clrwait_handshake", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.shot_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        model_op(1'b1, 8'h53, old, wr, nv);
        check("clrwait_result_valid", 32'(bus.result_valid), 32'd1);
        check("clrwait_code", 32'(bus.result_code), 32'(old));
        check("clrwait_we", 32'(bus.mem_write_enable), 32'(wr));
        watch_clear("pend_clear");
        model_clear();
        run_op("after_clear_shot", 1'b1, 4'd3, 4'd5);

        // Reset asserted in UPDATE: outputs drop at once, then the full clear restarts.
        @(negedge clk);
        bus.place_x = 4'd9; bus.place_y = 4'd9; bus.place_valid = 1'b1;
        wait_ready(1'b0, ok);
        check("rstupd_handshake", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.place_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstupd_result_valid", 32'(bus.result_valid), 32'd0);
        check("rstupd_we", 32'(bus.mem_write_enable), 32'd0);
        check("rstupd_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("rstupd_result_negedge", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_clear("rst_clear");
        model_clear();
        pref = 1'b0;
        run_op("after_rst_place", 1'b0, 4'd9, 4'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
